request_unit: RTL
=================

// Module: request_unit
// PURPOSE
//  Memory request sequencer between the control unit and the memory/cache port of the
//  single-cycle MIPS datapath. Consumes the control unit's data-request decode
//  (MemRead/MemWr) and HALT detect. Drives imem/dmem read/write enables, produces the
//  pc_en that advances the PC, counts stall cycles and flags data-access timeouts.
// PARAMETERS
//  MAX_WAIT  64  dmem wait cycles in DATA before timeout_err sets (>=1)
//  CNT_W     32  width of stall_cnt performance counter
// PORTS
//  CLK        in   1      system clock, all state on rising edge
//  RST        in   1      synchronous reset, active-high
//  ctrl_dREN  in   1      control MemRead for current instruction
//  ctrl_dWEN  in   1      control MemWr for current instruction
//  ctrl_halt  in   1      control decoded HALT opcode
//  ihit       in   1      instruction word valid this cycle
//  dhit       in   1      data access complete this cycle
//  imemREN    out  1      instruction fetch request
//  dmemREN    out  1      data read request
//  dmemWEN    out  1      data write request
//  pc_en      out  1      one-cycle PC advance strobe
//  halt       out  1      sticky halted indication
//  stall_cnt  out  CNT_W  cycles imemREN/dmem request asserted without its hit
//  timeout_err out 1      sticky: DATA exceeded MAX_WAIT cycles
// BEHAVIOUR
//  One clock domain: CLK. Reset synchronous, active-high on RST: state<=FETCH,
//   stall_cnt<=0, wait_cnt<=0, halt<=0, timeout_err<=0; while RST=1 all outputs 0.
//  Outputs: enables Moore-decoded from state; pc_en Mealy (state & hit).
//  States FETCH, DATA, HALTED:
//   FETCH: imemREN=1. ihit=0 -> stay, stall_cnt++. ihit=1 and (ctrl_dREN|ctrl_dWEN)
//    -> latch rd_q=ctrl_dREN&~ctrl_dWEN, wr_q=ctrl_dWEN; go DATA; pc_en=0.
//    ihit=1 and ctrl_halt (no data req) -> HALTED, pc_en=0. else ihit=1 -> pc_en=1, stay.
//    dhit in FETCH ignored.
//   DATA: imemREN=0, dmemREN=rd_q, dmemWEN=wr_q. dhit=1 -> pc_en=1, wait_cnt<=0, FETCH.
//    dhit=0 -> stall_cnt++, wait_cnt++; wait_cnt reaching MAX_WAIT sets timeout_err
//    (sticky); state stays DATA (no abort). ihit ignored.
//   HALTED: all enables 0, pc_en=0, halt=1; only RST exits.
//  ctrl_dREN & ctrl_dWEN together: treated as write (wr_q=1, rd_q=0).
//  ctrl_halt with data request: data access first; HALT not honoured (control never
//   co-asserts; no special handling).
//  dmemREN/dmemWEN never both 1; imemREN never 1 with either dmem enable.
//  Latency: non-memory instr 1 cycle after ihit (pc_en same cycle as ihit);
//   lw/sw: ihit cycle + >=1 DATA cycle, pc_en in dhit cycle.
//  stall_cnt saturates at all-ones (no wrap). wait_cnt saturates at MAX_WAIT.
//  Reset mid-DATA: request drops same cycle RST seen; FETCH after RST deasserts.
// STRUCTURE
//  cpu_types_pkg: typedef enum logic [1:0] {FETCH, DATA, HALTED} req_state_t.
//  One sub-module: sat_counter #(W) (clear, inc, saturating) used for stall_cnt and
//   wait_cnt. Rest is state reg + next-state/output comb block.
// TESTING
//  RST 1 cycle, ihit=1, no ctrl reqs -> imemREN=1, pc_en=1 every cycle, stall_cnt=0.
//  ihit=1 with ctrl_dREN=1, dhit after 3 cycles -> DATA 3 cycles dmemREN=1,
//   pc_en=1 only on dhit cycle, stall_cnt=2.
//  ctrl_dREN=ctrl_dWEN=1 -> dmemWEN=1, dmemREN=0 throughout DATA.
//  DATA with dhit held 0 for 70 cycles, MAX_WAIT=64 -> timeout_err=1 at wait 64, sticky.
//  ihit=1 with ctrl_halt=1 -> halt=1 next cycle, all enables 0, stays until RST.
//  RST asserted mid-DATA -> dmemREN=0 same cycle; after release FETCH, counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the request sequencer: FSM state encoding.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } req_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset/clear that holds at Max instead of wrapping.
module sat_counter #(
   parameter int unsigned    W   = 8,
   parameter logic [W-1:0]   Max = '1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != Max)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: fetch / data-access / halt FSM driving the memory enables,
// the PC advance strobe, a stall performance counter and a sticky data timeout flag.
module request_unit
   import cpu_types_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 64,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ctrl_dREN,
   input  logic             ctrl_dWEN,
   input  logic             ctrl_halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             timeout_err
);

   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

   req_state_t       state_q, state_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic             timeout_q, timeout_d;
   logic             pc_en_raw;
   logic             stall_inc;
   logic             wait_inc;
   logic             wait_clr;
   logic [CNT_W-1:0] stall_q;
   logic [WaitW-1:0] wait_q;

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      pc_en_raw = 1'b0;
      stall_inc = 1'b0;
      wait_inc  = 1'b0;
      wait_clr  = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (!ihit) begin
               stall_inc = 1'b1;
            end else if (ctrl_dREN || ctrl_dWEN) begin
               // A simultaneous read and write request is served as a write.
               rd_d    = ctrl_dREN & ~ctrl_dWEN;
               wr_d    = ctrl_dWEN;
               state_d = DATA;
            end else if (ctrl_halt) begin
               state_d = HALTED;
            end else begin
               pc_en_raw = 1'b1;
            end
         end
         DATA: begin
            if (dhit) begin
               pc_en_raw = 1'b1;
               wait_clr  = 1'b1;
               state_d   = FETCH;
            end else begin
               stall_inc = 1'b1;
               wait_inc  = 1'b1;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign timeout_d = timeout_q | (wait_inc && (wait_q == WaitW'(MAX_WAIT - 1)));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= FETCH;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(
      .W   (CNT_W),
      .Max ({CNT_W{1'b1}})
   ) u_stall_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (1'b0),
      .inc_i (stall_inc),
      .cnt_o (stall_q)
   );

   sat_counter #(
      .W   (WaitW),
      .Max (WaitW'(MAX_WAIT))
   ) u_wait_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (wait_clr),
      .inc_i (wait_inc),
      .cnt_o (wait_q)
   );

   // Reset is synchronous, so every output is also masked while RST is held.
   assign imemREN     = ~RST & (state_q == FETCH);
   assign dmemREN     = ~RST & (state_q == DATA) & rd_q;
   assign dmemWEN     = ~RST & (state_q == DATA) & wr_q;
   assign pc_en       = ~RST & pc_en_raw;
   assign halt        = ~RST & (state_q == HALTED);
   assign stall_cnt   = RST ? '0 : stall_q;
   assign timeout_err = ~RST & timeout_q;

endmodule
